vote_tally_fsm: RTL
===================

Name: vote_tally_fsm

Overview:
- Booth-side vote capture and tally stage.
- Arms on a ballot-officer enable, accepts exactly one debounced candidate button press per arming, and increments that candidate's 3-digit BCD tally (0-999, saturating).
- Presents the selected candidate's tally as three BCD digits (ones/tens/hundreds) that drive the downstream three-digit 7-segment display stage directly.

Parameters:
- N_CAND, 4, number of candidates; 2..8.
- SEL_W, 2, width of disp_sel; must be >= clog2(N_CAND).
- DEBOUNCE_CYC, 16, consecutive stable cycles required to accept a press; >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high; clears every tally and the FSM.
- ballot_en  input  1  officer arm request; rising edge arms one vote.
- vote_btn  input  N_CAND  candidate buttons, one-hot when valid, active-high, synchronous to clk.
- disp_sel  input  SEL_W  candidate whose tally is displayed.
- digit_ones  output  4  BCD ones digit of tally[disp_sel].
- digit_tens  output  4  BCD tens digit.
- digit_hund  output  4  BCD hundreds digit.
- ready  output  1  high while ARMED (booth accepting a vote).
- voted_pulse  output  1  one-cycle pulse in the COMMIT cycle.
- err_multi  output  1  one-cycle pulse when a multi-button press is first seen in ARMED.
- sat  output  1  high while tally[disp_sel] == 999.

Behaviour:
- Reset (synchronous, active-high):
  - State = IDLE; all tallies = 0; debounce counter = 0; ballot_en history = 0.
  - ready = 0, voted_pulse = 0, err_multi = 0, sat = 0; digits = 0.
- Registers: one registered copy of ballot_en for edge detection; rise = ballot_en & ~prev.
- IDLE:
  - On rise -> ARMED next cycle.
  - Level-high ballot_en held over from a previous vote does not re-arm.
- ARMED (ready = 1):
  - Exactly one vote_btn bit high: if it equals the latched candidate, the debounce counter increments; otherwise the candidate is latched and the counter is set to 1.
  - Counter reaching DEBOUNCE_CYC -> COMMIT.
  - Zero buttons: counter cleared.
  - More than one button: counter cleared and err_multi pulses on the first such cycle only. The FSM stays ARMED, and a new press is not counted until all buttons are released.
  - ballot_en activity is ignored while ARMED.
- COMMIT (1 cycle):
  - voted_pulse = 1.
  - The latched candidate's tally increments by 1 in BCD: ones 9->0 carries into tens, tens 9->0 carries into hundreds.
  - At 999 the tally holds at 999 (saturate, no wrap); voted_pulse still asserts.
  - -> WAIT_REL.
- WAIT_REL:
  - Holds until vote_btn == 0, then -> IDLE.
  - A button held indefinitely blocks re-arming; this is intended.
- Display path:
  - digits and sat are combinational from the tally registers, selected by disp_sel.
  - A committed vote is visible on the digits the cycle after COMMIT.
  - disp_sel >= N_CAND -> digits 0, sat 0.
- Each BCD digit register only ever holds values 0-9.
- Reset mid-operation (any state, including COMMIT) discards the pending vote and clears all tallies.
- Simultaneous reset and rise: reset wins; no arming.

Optional Feature:
- Macro: VOTE_TOTAL_EN.
- Defined:
  - Adds outputs total_ones, total_tens, total_hund (4 bits each): a separate BCD total of all committed votes, incremented in COMMIT and saturating at 999 independently of the per-candidate tallies.
  - Reset clears it.
- Undefined: no total register and no total ports.

Decomposition:
- Shared package vote_pkg:
  - state enum: IDLE, ARMED, COMMIT, WAIT_REL;
  - BCD digit type (4-bit);
  - BCD_MAX constant = 9;
  - TALLY_MAX = 999.
- Sub-module bcd3_incr_sat:
  - combinational 3-digit BCD +1 with saturation at 999;
  - instantiated once per tally (and once for the total when VOTE_TOTAL_EN is defined).

Test Plan:
- Reset, then rise on ballot_en, vote_btn = 4'b0010 held 16 cycles -> voted_pulse once; with disp_sel = 1, digits read 0/0/1; other candidates remain 0.
- Press 4'b0100 for 10 cycles, release, then press for 16 cycles -> exactly one commit to candidate 2; ready stays 1 until the commit.
- Press 4'b0011 in ARMED -> err_multi pulses once; no commit; then release and press 4'b0001 for 16 cycles -> candidate 0 = 1.
- Preload candidate 3 to 099 via 99 votes, then one more vote -> digits 1/0/0 (hund/tens/ones). Continue to 999 and vote again -> stays 999, sat = 1, voted_pulse still pulses.
- Hold ballot_en high across a commit, then release the button -> FSM stays IDLE, ready = 0; a new rise re-arms.
- Assert reset during the debounce count and during COMMIT -> all tallies 0, state IDLE, no voted_pulse afterwards.

Source files
------------

// File: rtl/vote_tally_fsm_pkg.sv
// ---------------------------------------------------------------------------
// vote_pkg : shared types and constants for the vote tally stage.
//   state_e       - booth FSM states (IDLE, ARMED, COMMIT, WAIT_REL)
//   bcd_t         - one 4-bit BCD digit
//   tally_t       - three BCD digits {hund, tens, ones}
//   BCD_MAX       - largest legal BCD digit value (9)
//   TALLY_MAX     - largest tally value (999); TALLY_MAX_BCD is its BCD form
// Optional feature macro used elsewhere in the slice: VOTE_TOTAL_EN.
// ---------------------------------------------------------------------------
package vote_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        COMMIT   = 2'd2,
        WAIT_REL = 2'd3
    } state_e;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t hund;
        bcd_t tens;
        bcd_t ones;
    } tally_t;

    localparam bcd_t   BCD_MAX       = 4'd9;
    localparam int     TALLY_MAX     = 999;
    localparam tally_t TALLY_MAX_BCD = '{hund: BCD_MAX, tens: BCD_MAX, ones: BCD_MAX};
    localparam tally_t TALLY_ZERO    = '{hund: 4'd0, tens: 4'd0, ones: 4'd0};

endpackage

// File: rtl/vote_tally_fsm_if.sv
// ---------------------------------------------------------------------------
// vote_tally_fsm_if : booth-side bus of the vote tally stage.
//   ballot_en   officer arm request (rising edge arms one vote)
//   vote_btn    N_CAND candidate buttons, one-hot when valid
//   disp_sel    candidate whose tally is shown
//   digit_*     BCD digits of the selected tally
//   ready       booth accepting a vote
//   voted_pulse one-cycle pulse on commit
//   err_multi   one-cycle pulse on first multi-button press
//   sat         selected tally is at 999
//   total_*     BCD total of all votes (only with VOTE_TOTAL_EN)
// Modports: master drives the inputs (officer/buttons/display select),
// slave is the tally stage itself.
// ---------------------------------------------------------------------------
interface vote_tally_fsm_if
    import vote_pkg::*;
#(
    parameter int N_CAND = 4,
    parameter int SEL_W  = 2
);
    logic              ballot_en;
    logic [N_CAND-1:0] vote_btn;
    logic [SEL_W-1:0]  disp_sel;
    bcd_t              digit_ones;
    bcd_t              digit_tens;
    bcd_t              digit_hund;
    logic              ready;
    logic              voted_pulse;
    logic              err_multi;
    logic              sat;
`ifdef VOTE_TOTAL_EN
    bcd_t              total_ones;
    bcd_t              total_tens;
    bcd_t              total_hund;
`endif

    modport master (
        output ballot_en, vote_btn, disp_sel,
`ifdef VOTE_TOTAL_EN
        input  total_ones, total_tens, total_hund,
`endif
        input  digit_ones, digit_tens, digit_hund, ready, voted_pulse, err_multi, sat
    );

    modport slave (
        input  ballot_en, vote_btn, disp_sel,
`ifdef VOTE_TOTAL_EN
        output total_ones, total_tens, total_hund,
`endif
        output digit_ones, digit_tens, digit_hund, ready, voted_pulse, err_multi, sat
    );

endinterface

// File: rtl/bcd3_incr_sat.sv
// ---------------------------------------------------------------------------
// bcd3_incr_sat : combinational three-digit BCD increment, saturating at 999.
//   val_i  current tally {hund, tens, ones}, each digit 0-9
//   val_o  val_i + 1 in BCD, or 999 unchanged when val_i is already 999
// ---------------------------------------------------------------------------
module bcd3_incr_sat
    import vote_pkg::*;
(
    input  tally_t val_i,
    output tally_t val_o
);

    // Ripple the +1 through the digits; a digit at 9 wraps to 0 and carries.
    always_comb begin
        val_o = val_i;
        if (val_i == TALLY_MAX_BCD) begin
            val_o = val_i;
        end else if (val_i.ones != BCD_MAX) begin
            val_o.ones = val_i.ones + 4'd1;
        end else if (val_i.tens != BCD_MAX) begin
            val_o.ones = 4'd0;
            val_o.tens = val_i.tens + 4'd1;
        end else begin
            // hund cannot be 9 here, otherwise the saturation branch was taken
            val_o.ones = 4'd0;
            val_o.tens = 4'd0;
            val_o.hund = val_i.hund + 4'd1;
        end
    end

endmodule

// File: rtl/vote_tally_fsm.sv
// ---------------------------------------------------------------------------
// vote_tally_fsm : booth-side vote capture and per-candidate BCD tally.
//   clk    system clock, rising edge
//   reset  synchronous active-high; clears FSM, debounce and all tallies
//   bus    vote_tally_fsm_if.slave (ballot_en, vote_btn, disp_sel in;
//          digits, ready, voted_pulse, err_multi, sat out)
// An officer rising edge on ballot_en arms the booth; one button held
// stable for DEBOUNCE_CYC cycles commits a vote, then the booth waits for
// all buttons to be released before it can be armed again.
// Optional feature: define VOTE_TOTAL_EN to add a saturating BCD total of
// all committed votes on bus.total_{ones,tens,hund}.
// ---------------------------------------------------------------------------
module vote_tally_fsm
    import vote_pkg::*;
#(
    parameter int N_CAND       = 4,
    parameter int SEL_W        = 2,
    parameter int DEBOUNCE_CYC = 16
)(
    input  logic             clk,
    input  logic             reset,
    vote_tally_fsm_if.slave  bus
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(DEBOUNCE_CYC);

    state_e             state_q, state_d;
    logic               prev_en_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_CAND-1:0]  cand_q, cand_d;
    logic               lock_q, lock_d;
    tally_t             tally_q     [N_CAND];
    tally_t             tally_inc_s [N_CAND];

    logic               rise_s;
    logic               btn_none_s;
    logic               btn_multi_s;
    logic               ready_s;
    logic               voted_s;
    logic               err_s;
    tally_t             sel_s;

    assign rise_s      = bus.ballot_en & ~prev_en_q;
    assign btn_none_s  = (bus.vote_btn == {N_CAND{1'b0}});
    // x & (x-1) clears the lowest set bit; anything left means two or more
    assign btn_multi_s = !btn_none_s &&
                         ((bus.vote_btn & (bus.vote_btn - N_CAND'(1))) != {N_CAND{1'b0}});

    genvar g;
    generate
        for (g = 0; g < N_CAND; g++) begin : g_incr
            bcd3_incr_sat u_incr (
                .val_i (tally_q[g]),
                .val_o (tally_inc_s[g])
            );
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Debounce counter, latched candidate and multi-press lockout.
    // The lockout is set by a multi-press and only released when every
    // button is up, so a partial release does not start a new count.
    always_comb begin
        cnt_d  = cnt_q;
        cand_d = cand_q;
        lock_d = lock_q;
        case (state_q)
            ARMED: begin
                if (btn_none_s) begin
                    cnt_d  = {CNT_W{1'b0}};
                    lock_d = 1'b0;
                end else if (btn_multi_s) begin
                    cnt_d  = {CNT_W{1'b0}};
                    lock_d = 1'b1;
                end else if (lock_q) begin
                    cnt_d  = {CNT_W{1'b0}};
                end else if (bus.vote_btn == cand_q) begin
                    cnt_d  = cnt_q + CNT_W'(1);
                end else begin
                    cand_d = bus.vote_btn;
                    cnt_d  = CNT_W'(1);
                end
            end
            default: begin
                cnt_d  = {CNT_W{1'b0}};
                lock_d = 1'b0;
            end
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = rise_s ? ARMED : IDLE;
            ARMED:    state_d = (cnt_d == CNT_DONE) ? COMMIT : ARMED;
            COMMIT:   state_d = WAIT_REL;
            WAIT_REL: state_d = btn_none_s ? IDLE : WAIT_REL;
            default:  state_d = IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        ready_s = 1'b0;
        voted_s = 1'b0;
        err_s   = 1'b0;
        case (state_q)
            ARMED: begin
                ready_s = 1'b1;
                err_s   = btn_multi_s & ~lock_q;
            end
            COMMIT:  voted_s = 1'b1;
            default: begin
                ready_s = 1'b0;
                voted_s = 1'b0;
                err_s   = 1'b0;
            end
        endcase
    end

    // Arming edge history and debounce bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_en_q <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
            cand_q    <= {N_CAND{1'b0}};
            lock_q    <= 1'b0;
        end else begin
            prev_en_q <= bus.ballot_en;
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            lock_q    <= lock_d;
        end
    end

    // Per-candidate tallies; only the latched candidate moves in COMMIT.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CAND; i++) begin
            if (reset) begin
                tally_q[i] <= TALLY_ZERO;
            end else if ((state_q == COMMIT) && cand_q[i]) begin
                tally_q[i] <= tally_inc_s[i];
            end else begin
                tally_q[i] <= tally_q[i];
            end
        end
    end

    // Display mux; an out-of-range select matches no candidate and shows 0.
    always_comb begin
        sel_s = TALLY_ZERO;
        for (int i = 0; i < N_CAND; i++) begin
            sel_s = (bus.disp_sel == SEL_W'(i)) ? tally_q[i] : sel_s;
        end
    end

    assign bus.digit_ones  = sel_s.ones;
    assign bus.digit_tens  = sel_s.tens;
    assign bus.digit_hund  = sel_s.hund;
    assign bus.sat         = (sel_s == TALLY_MAX_BCD);
    assign bus.ready       = ready_s;
    assign bus.voted_pulse = voted_s;
    assign bus.err_multi   = err_s;

`ifdef VOTE_TOTAL_EN
    tally_t total_q;
    tally_t total_inc_s;

    bcd3_incr_sat u_total_incr (
        .val_i (total_q),
        .val_o (total_inc_s)
    );

    // Grand total of committed votes, saturating on its own.
    always_ff @(posedge clk) begin
        if (reset) begin
            total_q <= TALLY_ZERO;
        end else if (state_q == COMMIT) begin
            total_q <= total_inc_s;
        end else begin
            total_q <= total_q;
        end
    end

    assign bus.total_ones = total_q.ones;
    assign bus.total_tens = total_q.tens;
    assign bus.total_hund = total_q.hund;
`endif

endmodule
